// File: rtl/axi_mem_if_pkg.sv
// Shared types and encodings for the AXI memory-port arbiter slice.
// Holds the arbitration side enum, active-low SRAM encodings and counter width.
`timescale 1ns/1ps
package axi_mem_if_pkg;

    typedef enum logic {
        ARB_READ  = 1'b0,
        ARB_WRITE = 1'b1
    } arb_side_t;

    localparam logic CEN_ON    = 1'b0;
    localparam logic CEN_OFF   = 1'b1;
    localparam logic WEN_WRITE = 1'b0;
    localparam logic WEN_READ  = 1'b1;

    localparam int CONSEC_CNT_WIDTH = 4;

    // Saturating increment: a long streak pins at all-ones instead of wrapping.
    function automatic logic [CONSEC_CNT_WIDTH-1:0] sat_inc(
        input logic [CONSEC_CNT_WIDTH-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_rdata_pipe.sv
// Read-return path: MEM_LATENCY-deep valid shift plus a holding data register.
// Ports: clk, rst_n, i_load (read granted), i_mem_q (SRAM Q), o_rdata, o_rvalid.
`timescale 1ns/1ps
module mem_rdata_pipe
    import axi_mem_if_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_mem_q,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rvalid
);

    logic [MEM_LATENCY-1:0] r_vld;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic                   r_rvalid;
    logic                   w_tail;

    assign w_tail = r_vld[MEM_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld    <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_vld[0] <= i_load;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
            // Tail marks the cycle in which Q carries this read's word.
            r_rvalid <= w_tail;
            if (w_tail) begin
                r_rdata <= i_mem_q;
            end
        end
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;

endmodule

// File: rtl/axi_mem_port_arbiter.sv
// Round-robin arbiter of AXI read/write beat requests onto one single-port SRAM.
// Ports: rd_* read request/return, wr_* write request, MEM_* SRAM port.
`timescale 1ns/1ps
module axi_mem_port_arbiter
    import axi_mem_if_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 13,
    parameter int DATA_WIDTH     = 64,
    parameter int NUMBYTES       = DATA_WIDTH / 8,
    parameter int MEM_LATENCY    = 1,
    parameter int MAX_CONSEC     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rd_valid_i,
    output logic                      rd_grant_o,
    input  logic [MEM_ADDR_WIDTH-1:0] rd_A_i,
    output logic [DATA_WIDTH-1:0]     rd_rdata_o,
    output logic                      rd_rvalid_o,
    input  logic                      wr_valid_i,
    output logic                      wr_grant_o,
    input  logic [MEM_ADDR_WIDTH-1:0] wr_A_i,
    input  logic [DATA_WIDTH-1:0]     wr_D_i,
    input  logic [NUMBYTES-1:0]       wr_BE_i,
    output logic                      MEM_CEN_o,
    output logic                      MEM_WEN_o,
    output logic [MEM_ADDR_WIDTH-1:0] MEM_A_o,
    output logic [DATA_WIDTH-1:0]     MEM_D_o,
    output logic [NUMBYTES-1:0]       MEM_BE_o,
    input  logic [DATA_WIDTH-1:0]     MEM_Q_i
);

    localparam logic [CONSEC_CNT_WIDTH-1:0] LP_MAX =
        CONSEC_CNT_WIDTH'(MAX_CONSEC);

    arb_side_t                     r_last;
    logic [CONSEC_CNT_WIDTH-1:0]   r_cnt;

    logic      w_rd_req;
    logic      w_wr_req;
    logic      w_stay;
    logic      w_rd_win;
    logic      w_wr_win;
    logic      w_any;
    arb_side_t w_win;

    // Requests are masked during reset so no grant escapes before release.
    assign w_rd_req = rd_valid_i & rst_n;
    assign w_wr_req = wr_valid_i & rst_n;

    // A zero count means no streak exists yet, so the reset-time last winner
    // cannot claim the first contention; otherwise keep the streak going
    // until the window is used up.
    assign w_stay = (r_cnt != '0) && (r_cnt < LP_MAX);

    always_comb begin
        w_rd_win = 1'b0;
        w_wr_win = 1'b0;
        unique case (1'b1)
            (w_rd_req && !w_wr_req): w_rd_win = 1'b1;
            (w_wr_req && !w_rd_req): w_wr_win = 1'b1;
            (w_rd_req && w_wr_req): begin
                if (w_stay) begin
                    w_rd_win = (r_last == ARB_READ);
                    w_wr_win = (r_last == ARB_WRITE);
                end else begin
                    w_rd_win = (r_last == ARB_WRITE);
                    w_wr_win = (r_last == ARB_READ);
                end
            end
            default: ;
        endcase
    end

    assign w_any = w_rd_win | w_wr_win;
    assign w_win = w_rd_win ? ARB_READ : ARB_WRITE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= ARB_WRITE;
            r_cnt  <= '0;
        end else if (w_any) begin
            r_last <= w_win;
            r_cnt  <= (w_win == r_last) ? sat_inc(r_cnt)
                                        : CONSEC_CNT_WIDTH'(1);
        end
    end

    assign rd_grant_o = w_rd_win;
    assign wr_grant_o = w_wr_win;

    assign MEM_CEN_o = w_any    ? CEN_ON    : CEN_OFF;
    assign MEM_WEN_o = w_wr_win ? WEN_WRITE : WEN_READ;
    assign MEM_A_o   = w_rd_win ? rd_A_i    : wr_A_i;
    assign MEM_D_o   = wr_D_i;
    assign MEM_BE_o  = w_rd_win ? '1        : wr_BE_i;

    mem_rdata_pipe #(
        .MEM_LATENCY (MEM_LATENCY),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_rdata_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_rd_win),
        .i_mem_q  (MEM_Q_i),
        .o_rdata  (rd_rdata_o),
        .o_rvalid (rd_rvalid_o)
    );

endmodule
